divisor_seq: RTL and testbench

DIVISOR_SEQ -- requirements
Module: divisor_seq

---
 rtl/divisor_seq.sv | 158 +++++++++++++++
 tb/tb_divisor_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_seq.sv
//------------------------------------------------------------------------------
// divisor_seq
//------------------------------------------------------------------------------
// Sequential signed 32-bit divider using one restoring step per clock.
// Operands are converted to magnitudes on acceptance. Signs are applied in a
// final fix-up state. The result appears on hi/lo together with a one-cycle
// done pulse, 34 rising edges after start is sampled.
//
// Ports:
//   clk      - sole clock, rising edge
//   reset    - asynchronous, active-high
//   a        - dividend, two's complement
//   b        - divisor, two's complement
//   start    - divide request, sampled only while idle
//   done     - one-cycle pulse, hi/lo hold a fresh result
//   div_zero - one-cycle pulse, request had a zero divisor
//   hi       - remainder (sign of dividend)
//   lo       - quotient (truncated toward zero)
//
// Build option:
//   DIVISOR_SEQ_FASTPATH_EN - when defined, |a| < |b| skips the iteration
//                             phase, and done pulses 2 edges after start.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module divisor_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_sign_a;
    logic        r_sign_b;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fast;

    // Magnitudes. -2^31 maps to 0x80000000, which is still correct as unsigned.
    assign w_abs_a = a[31] ? (~a + 32'd1) : a;
    assign w_abs_b = b[31] ? (~b + 32'd1) : b;

    // One restoring step. The partial remainder is always below |b| <= 2^31,
    // so the shifted value fits in 32 bits. Bit 32 of the difference is the
    // borrow.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

`ifdef DIVISOR_SEQ_FASTPATH_EN
    assign w_fast = (w_abs_a < w_abs_b);
`else
    assign w_fast = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 6'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_dvs    <= 32'd0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (b == 32'd0) begin
                            div_zero <= 1'b1;
                        end else begin
                            r_dvs    <= w_abs_b;
                            r_sign_a <= a[31];
                            r_sign_b <= b[31];
                            r_cnt    <= 6'd0;
                            if (w_fast) begin
                                // Quotient is zero and the remainder is |a|.
                                // The fix-up state restores the sign of a.
                                r_rem   <= w_abs_a;
                                r_quo   <= 32'd0;
                                r_state <= ST_FIX;
                            end else begin
                                r_rem   <= 32'd0;
                                r_quo   <= w_abs_a;
                                r_state <= ST_RUN;
                            end
                        end
                    end
                end

                ST_RUN: begin
                    if (w_diff[32]) begin
                        r_rem <= w_shift[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end else begin
                        r_rem <= w_diff[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    if (r_sign_a ^ r_sign_b) begin
                        r_quo <= ~r_quo + 32'd1;
                    end
                    if (r_sign_a) begin
                        r_rem <= ~r_rem + 32'd1;
                    end
                    r_state <= ST_DONE;
                end

                ST_DONE: begin
                    hi      <= r_rem;
                    lo      <= r_quo;
                    done    <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divisor_seq.sv
//------------------------------------------------------------------------------
// tb_divisor_seq
//------------------------------------------------------------------------------
// Self-checking bench for divisor_seq. Results come from a signed 64-bit
// arithmetic reference. Operation latency and flag behaviour are checked
// against the expected values.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_divisor_seq;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int err_cnt;
    int chk_cnt;

    divisor_seq u_dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .start    (start),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Truncating signed division computed in 64 bits, so -2^31/-1 does not
    // overflow. The low 32 bits give the wrapped quotient.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa;
        longint sb;
        longint q64;
        longint r64;
        logic [63:0] qv;
        logic [63:0] rv;
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        q64 = sa / sb;
        r64 = sa % sb;
        qv  = q64;
        rv  = r64;
        q   = qv[31:0];
        r   = rv[31:0];
        lat = 34;
`ifdef DIVISOR_SEQ_FASTPATH_EN
        if ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb)) lat = 2;
`endif
    endtask

    task automatic run_div(input logic [31:0] ta, input logic [31:0] tbv, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        int lat;
        int seen;
        int pulses;
        int leak;
        old_hi = hi;
        old_lo = lo;
        @(negedge clk);
        a = ta; b = tbv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        if (tbv == 32'd0) begin
            check_val({tag, "_dz_pulse"}, div_zero, 1);
            check_val({tag, "_dz_done"}, done, 0);
            check_val({tag, "_dz_hi"}, hi, old_hi);
            check_val({tag, "_dz_lo"}, lo, old_lo);
            @(posedge clk);
            #1;
            check_val({tag, "_dz_end"}, {done, div_zero}, 0);
            return;
        end
        model(ta, tbv, eq, er, lat);
        seen = 0; pulses = 0; leak = 0;
        got_hi = 32'd0; got_lo = 32'd0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (div_zero) leak = 1;
            if (done) begin
                pulses++;
                if (seen == 0) begin
                    seen = n;
                    got_hi = hi;
                    got_lo = lo;
                end
            end else if (seen == 0 && (hi !== old_hi || lo !== old_lo)) begin
                leak = 1;
            end
        end
        check_val({tag, "_latency"}, seen, lat);
        check_val({tag, "_pulses"}, pulses, 1);
        check_val({tag, "_lo"}, got_lo, eq);
        check_val({tag, "_hi"}, got_hi, er);
        check_val({tag, "_stable"}, leak, 0);
    endtask

    task automatic run_hold();
        int first;
        int second;
        int pulses;
        @(negedge clk);
        a = 32'd20; b = 32'd3; start = 1'b1;
        @(posedge clk);
        first = 0; second = 0; pulses = 0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (first == 0) first = n;
                else if (second == 0) begin
                    second = n;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_val("hold_first", first, 34);
        check_val("hold_second", second, 69);
        check_val("hold_pulses", pulses, 2);
        check_val("hold_lo", lo, 32'd6);
        check_val("hold_hi", hi, 32'd2);
    endtask

    task automatic run_reset_abort();
        int seen;
        @(negedge clk);
        a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_val("rst_async", {done, div_zero, hi, lo}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done || hi != 0 || lo != 0) seen = 1;
        end
        check_val("rst_abort", seen, 0);
        run_div(32'd100, 32'd7, "after_rst");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int sel;
        err_cnt = 0;
        chk_cnt = 0;
        reset = 1'b1;
        a = 32'd0; b = 32'd0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_state", {done, div_zero, hi, lo}, 0);
        @(negedge clk);
        reset = 1'b0;

        run_div(32'd7, 32'd2, "p7_2");
        run_div(32'hFFFFFFF9, 32'd2, "m7_2");
        run_div(32'd7, 32'hFFFFFFFE, "p7_m2");
        run_div(32'd5, 32'd0, "div0");
        run_div(32'h80000000, 32'hFFFFFFFF, "ovf");
        run_div(32'd3, 32'd10, "small");
        run_div(32'hFFFFFFFD, 32'd10, "small_neg");
        run_div(32'd0, 32'd5, "zero_a");
        run_div(32'h12345678, 32'd1, "by_one");
        run_div(32'h7FFFFFFF, 32'h80000000, "by_min");
        run_div(32'h80000000, 32'h80000000, "min_min");

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = 32'd0;
            else if (sel < 4) rb = (sel == 1) ? 32'd0 - $urandom_range(1, 15) : $urandom_range(1, 15);
            if (sel == 5) ra = $urandom_range(0, 20);
            run_div(ra, rb, $sformatf("rnd%0d", i));
        end

        run_hold();
        run_reset_abort();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
